spi_reg_master: RTL and testbench

- SPI initiator that issues single-register read/write transactions to the FPGA register-file SPI slave.
- Used in on-chip loopback/self-test benches and as the host-side model.
- A frame is 16 bits, SPI mode 0, MSB first.
  - Byte 0 = {rw, regnum[6:0]}, where rw=1 means write and rw=0 means read.
  - Byte 1 = write data on mosi, or read data returned on miso.

---
 rtl/spi_reg_master.sv | 114 +++++++++++
 tb/tb_spi_reg_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 initiator issuing 16-bit register read/write frames.
// Frame = {rw, regnum[6:0]} then data byte; rdata is updated at done of a read.
module spi_reg_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2,
    parameter int SS_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       write,
    input  logic [6:0] regnum,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ss
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_L  = 8'(CLK_DIV - 1);
    localparam logic [7:0] SET_L  = 8'(SS_SETUP - 1);
    localparam logic [7:0] HOLD_L = 8'(SS_HOLD - 1);
    localparam logic [7:0] GAP_L  = 8'(SS_GAP - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_cnt;
    logic [14:0] shift_tx;
    logic [7:0]  shift_rx;
    logic        rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ss       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            cnt      <= 8'd0;
            bit_cnt  <= 4'd0;
            shift_tx <= 15'd0;
            shift_rx <= 8'h00;
            rd       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // the done cycle still reads as idle, but a start there is dropped
                    if (start && !done) begin
                        shift_tx <= {regnum, wdata};
                        rd       <= !write;
                        mosi     <= write;
                        ss       <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= 8'd0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SET_L) begin
                        cnt     <= 8'd0;
                        bit_cnt <= 4'd15;
                        state   <= SHIFT_LO;
                    end else cnt <= cnt + 8'd1;
                end
                SHIFT_LO: begin
                    if (cnt == DIV_L) begin
                        cnt      <= 8'd0;
                        sclk     <= 1'b1;
                        shift_rx <= {shift_rx[6:0], miso};
                        state    <= SHIFT_HI;
                    end else cnt <= cnt + 8'd1;
                end
                SHIFT_HI: begin
                    if (cnt == DIV_L) begin
                        cnt  <= 8'd0;
                        sclk <= 1'b0;
                        if (bit_cnt == 4'd0) state <= HOLD;
                        else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            mosi    <= shift_tx[bit_cnt - 4'd1];
                            state   <= SHIFT_LO;
                        end
                    end else cnt <= cnt + 8'd1;
                end
                HOLD: begin
                    if (cnt == HOLD_L) begin
                        cnt   <= 8'd0;
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= GAP;
                    end else cnt <= cnt + 8'd1;
                end
                GAP: begin
                    if (cnt == GAP_L) begin
                        cnt   <= 8'd0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        rdata <= rd ? shift_rx : rdata;
                        state <= IDLE;
                    end else cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: two masters (default and minimum timing) sharing one
// behavioural register-file SPI slave; a queue holds each frame's expected outcome.
module tb_spi_reg_master;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, write = 1'b0, sel = 1'b0;
    logic [6:0] regnum = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       a_busy, a_done, a_sclk, a_mosi, a_ss;
    logic       b_busy, b_done, b_sclk, b_mosi, b_ss;
    logic [7:0] a_rdata, b_rdata;
    logic       miso;
    logic       a_start, b_start;

    always #5 clk = ~clk;

    assign a_start = start && !sel;
    assign b_start = start && sel;

    spi_reg_master dut_a (
        .clk(clk), .rst(rst), .start(a_start), .write(write), .regnum(regnum), .wdata(wdata),
        .busy(a_busy), .done(a_done), .rdata(a_rdata), .sclk(a_sclk), .mosi(a_mosi),
        .miso(miso), .ss(a_ss));

    spi_reg_master #(.CLK_DIV(1), .SS_SETUP(1), .SS_HOLD(1), .SS_GAP(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .write(write), .regnum(regnum), .wdata(wdata),
        .busy(b_busy), .done(b_done), .rdata(b_rdata), .sclk(b_sclk), .mosi(b_mosi),
        .miso(miso), .ss(b_ss));

    logic       s_sclk, s_mosi, s_ss, s_busy, s_done;
    logic [7:0] s_rdata;
    assign s_sclk  = sel ? b_sclk  : a_sclk;
    assign s_mosi  = sel ? b_mosi  : a_mosi;
    assign s_ss    = sel ? b_ss    : a_ss;
    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;
    assign s_rdata = sel ? b_rdata : a_rdata;

    // register-file slave: reg 0x0B is the clock divisor
    logic [7:0]  regs [128] = '{1: 8'hFF, 7: 8'h13, default: 8'h00};
    logic [15:0] rx = 16'h0000;
    logic [7:0]  hdr = 8'h00;
    logic [7:0]  rv;
    logic [7:0]  clock_divisor;
    int          nbit = 16;
    int          stray = 0;

    assign clock_divisor = regs[11];

    always @(posedge s_sclk or negedge s_ss) begin
        if (!s_sclk) nbit = 0;
        else if (s_ss) stray++;
        else begin
            rx = {rx[14:0], s_mosi};
            nbit++;
            if (nbit == 8) hdr = rx[7:0];
        end
    end

    always @(posedge s_ss) if (nbit == 16 && rx[15]) regs[rx[14:8]] = rx[7:0];

    always_comb begin
        rv   = regs[hdr[6:0]];
        miso = (nbit >= 8 && nbit < 16 && !hdr[7]) ? rv[3'(15 - nbit)] : 1'b0;
    end

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
        int          len;
    } exp_t;
    exp_t q[$];

    int         checks = 0, failures = 0;
    logic [7:0] rd_a = 8'h00, rd_b = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic b, input logic w, input logic [6:0] r, input logic [7:0] d,
                       input logic [7:0] erd, input int len, input logic poke);
        exp_t e;
        int   cyc;
        sel = b;
        @(negedge clk);
        write = w; regnum = r; wdata = d; start = 1'b1;
        e.frame = {w, r, d};
        e.len   = len;
        e.rd    = w ? (b ? rd_b : rd_a) : erd;
        if (b) rd_b = e.rd; else rd_a = e.rd;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_accept", 32'(s_busy), 32'd1);
        check("ss_accept", 32'(s_ss), 32'd0);
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (poke && cyc == 40) begin start = 1'b1; regnum = 7'h55; end
            else start = 1'b0;
            if (s_done || cyc >= 400) break;
            @(posedge clk);
            cyc++;
        end
        e = q.pop_front();
        check("done_seen", 32'(s_done), 32'd1);
        check("frame_len", 32'(cyc), 32'(e.len));
        check("mosi_frame", 32'(rx), 32'(e.frame));
        check("sclk_rises", 32'(nbit), 32'd16);
        check("rdata", 32'(s_rdata), 32'(e.rd));
        check("busy_at_done", 32'(s_busy), 32'd0);
        check("ss_at_done", 32'(s_ss), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", 32'(s_busy), 32'd0);
        check("b2b_done", 32'(s_done), 32'd0);
    endtask

    initial begin
        int cyc;
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", 32'(a_ss), 32'd1);
        check("rst_sclk", 32'(a_sclk), 32'd0);
        check("rst_mosi", 32'(a_mosi), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_ss", 32'(b_ss), 32'd1);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;

        run(1'b0, 1'b1, 7'h05, 8'hA5, 8'h00, 135, 1'b0);
        run(1'b0, 1'b0, 7'h07, 8'h00, 8'h13, 135, 1'b0);
        run(1'b0, 1'b1, 7'h0B, 8'h3C, 8'h00, 135, 1'b0);
        run(1'b0, 1'b0, 7'h0B, 8'h00, 8'h3C, 135, 1'b0);
        check("clock_divisor", 32'(clock_divisor), 32'h3C);
        run(1'b0, 1'b1, 7'h20, 8'h5A, 8'h00, 135, 1'b1);

        // abort a write part-way through the shift phase
        sel = 1'b0;
        @(negedge clk);
        write = 1'b1; regnum = 7'h0D; wdata = 8'h77; start = 1'b1;
        e.frame = 16'h8D77; e.rd = rd_a; e.len = 135;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (nbit != 10 && cyc < 400) begin @(negedge clk); cyc++; end
        check("reach_bit6", 32'(nbit), 32'd10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ss", 32'(a_ss), 32'd1);
        check("abort_sclk", 32'(a_sclk), 32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        check("abort_rdata", 32'(a_rdata), 32'd0);
        rst = 1'b0;
        q.delete();
        rd_a = 8'h00;
        rd_b = 8'h00;
        check("abort_no_write", 32'(regs[13]), 32'd0);

        run(1'b0, 1'b1, 7'h0C, 8'h99, 8'h00, 135, 1'b0);
        run(1'b1, 1'b0, 7'h01, 8'h00, 8'hFF, 36, 1'b0);
        run(1'b1, 1'b0, 7'h02, 8'h00, 8'h00, 36, 1'b0);
        check("no_stray_sclk", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
